// File: rtl/bcd_display_scan.sv
// bcd_display_scan
// Multiplexed driver for a 6-digit common-anode 7-segment clock display
// (HH:MM:SS). Each digit is selected for SCAN_DIV cycles. Every slot opens
// with BLANK_CYC cycles of all-anodes-off so the previous digit's segment
// pattern never ghosts onto the next anode. Input digits are captured once
// per frame so a frame never mixes an old and a new time value. The colon
// (decimal points of digits 2 and 4) blinks at 1 Hz from tick_1hz.

module bcd_display_scan #(
    parameter int SCAN_DIV  = 1000,
    parameter int BLANK_CYC = 50,
    parameter int CNT_W     = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] hour_10,
    input  logic [3:0] hour1,
    input  logic [3:0] min_10,
    input  logic [3:0] min1,
    input  logic [3:0] sec_10,
    input  logic [3:0] sec1,
    input  logic       tick_1hz,
    input  logic       lz_blank,
    output logic [5:0] an_n,
    output logic [6:0] seg_n,
    output logic       dp_n
);

    // Terminal slot count, blanking threshold and last digit index.
    localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] LP_BLANK    = CNT_W'(BLANK_CYC);
    localparam logic [2:0]       LP_IDX_LAST = 3'd5;

    // All-off patterns for the active-low outputs.
    localparam logic [5:0] LP_AN_OFF  = 6'b111111;
    localparam logic [6:0] LP_SEG_OFF = 7'b1111111;

    // Scan position.
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_idx;

    // Colon blink state.
    logic             r_colonOn;

    // Frame snapshot of the six digits.
    logic [3:0]       r_snapSec1;
    logic [3:0]       r_snapSec10;
    logic [3:0]       r_snapMin1;
    logic [3:0]       r_snapMin10;
    logic [3:0]       r_snapHour1;
    logic [3:0]       r_snapHour10;

    // Registered outputs.
    logic [5:0]       r_anN;
    logic [6:0]       r_segN;
    logic             r_dpN;

    // Combinational helpers.
    logic             w_slotEnd;
    logic             w_frameEnd;
    logic             w_blank;
    logic [3:0]       w_digit;
    logic             w_lzSuppress;
    logic             w_colonSlot;
    logic [5:0]       w_anNext;
    logic [6:0]       w_segNext;
    logic             w_dpNext;

    // Active-low segment pattern {g,f,e,d,c,b,a}; codes 10..15 render blank.
    function automatic logic [6:0] decodeBcd(input logic [3:0] digit);
        logic [6:0] pattern;
        case (digit)
            4'd0:    pattern = 7'b1000000;
            4'd1:    pattern = 7'b1111001;
            4'd2:    pattern = 7'b0100100;
            4'd3:    pattern = 7'b0110000;
            4'd4:    pattern = 7'b0011001;
            4'd5:    pattern = 7'b0010010;
            4'd6:    pattern = 7'b0000010;
            4'd7:    pattern = 7'b1111000;
            4'd8:    pattern = 7'b0000000;
            4'd9:    pattern = 7'b0010000;
            default: pattern = 7'b1111111;
        endcase
        return pattern;
    endfunction

    // Slot and frame boundaries plus the anti-ghost window.
    always_comb begin
        w_slotEnd  = (r_cnt == LP_CNT_LAST);
        w_frameEnd = w_slotEnd && (r_idx == LP_IDX_LAST);
        w_blank    = (r_cnt < LP_BLANK);
    end

    // Pick the snapshot digit belonging to the current slot (0 = rightmost).
    always_comb begin
        w_digit = 4'hF;
        case (r_idx)
            3'd0:    w_digit = r_snapSec1;
            3'd1:    w_digit = r_snapSec10;
            3'd2:    w_digit = r_snapMin1;
            3'd3:    w_digit = r_snapMin10;
            3'd4:    w_digit = r_snapHour1;
            3'd5:    w_digit = r_snapHour10;
            default: w_digit = 4'hF;
        endcase
    end

    // Next output values for the current slot position; lz_blank is used
    // live so the user setting takes effect without waiting for a frame.
    always_comb begin
        w_lzSuppress = (r_idx == LP_IDX_LAST) && lz_blank && (r_snapHour10 == 4'd0);
        w_colonSlot  = (r_idx == 3'd2) || (r_idx == 3'd4);
        w_anNext     = ~(6'b000001 << r_idx);
        w_segNext    = w_lzSuppress ? LP_SEG_OFF : decodeBcd(w_digit);
        w_dpNext     = ~(r_colonOn && w_colonSlot);
    end

    // Slot counter and digit index: cnt runs 0..SCAN_DIV-1, idx 0..5.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (w_slotEnd) begin
            r_cnt <= '0;
            r_idx <= (r_idx == LP_IDX_LAST) ? 3'd0 : 3'(r_idx + 3'd1);
        end else begin
            r_cnt <= CNT_W'(r_cnt + 1'b1);
        end
    end

    // Capture all six digits together on the last cycle of the frame so the
    // next frame starts with a coherent time value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_snapSec1   <= '0;
            r_snapSec10  <= '0;
            r_snapMin1   <= '0;
            r_snapMin10  <= '0;
            r_snapHour1  <= '0;
            r_snapHour10 <= '0;
        end else if (w_frameEnd) begin
            r_snapSec1   <= sec1;
            r_snapSec10  <= sec_10;
            r_snapMin1   <= min1;
            r_snapMin10  <= min_10;
            r_snapHour1  <= hour1;
            r_snapHour10 <= hour_10;
        end
    end

    // Colon toggles once per second, independent of the frame snapshot.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_colonOn <= 1'b0;
        end else if (tick_1hz) begin
            r_colonOn <= ~r_colonOn;
        end
    end

    // Register the display outputs; everything is dark in the blank window.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_anN  <= LP_AN_OFF;
            r_segN <= LP_SEG_OFF;
            r_dpN  <= 1'b1;
        end else if (w_blank) begin
            r_anN  <= LP_AN_OFF;
            r_segN <= LP_SEG_OFF;
            r_dpN  <= 1'b1;
        end else begin
            r_anN  <= w_anNext;
            r_segN <= w_segNext;
            r_dpN  <= w_dpNext;
        end
    end

    assign an_n  = r_anN;
    assign seg_n = r_segN;
    assign dp_n  = r_dpN;

endmodule
